// File: rtl/load_align_unit.sv
// Load alignment unit: issues one word-aligned data-memory read per load,
// waits for the variable-latency response, then extracts, extends and
// merges the addressed bytes (big-endian lanes) into a single writeback beat.
module load_align_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_load_sel,
  input  logic [31:0]       req_rt_old,
  input  logic [REG_W-1:0]  req_dest,
  input  logic              flush,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_dest,
  output logic [31:0]       wb_data,
  output logic              addr_err,
  output logic              busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 3;

  localparam logic [SEL_W-1:0] SEL_LB  = 3'd0;
  localparam logic [SEL_W-1:0] SEL_LBU = 3'd1;
  localparam logic [SEL_W-1:0] SEL_LH  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_LHU = 3'd3;
  localparam logic [SEL_W-1:0] SEL_LW  = 3'd4;
  localparam logic [SEL_W-1:0] SEL_LWL = 3'd5;
  localparam logic [SEL_W-1:0] SEL_LWR = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              state_q;
  logic [1:0]          ofs_q;
  logic [SEL_W-1:0]    sel_q;
  logic [DATA_W-1:0]   rt_q;
  logic [REG_W-1:0]    dest_q;
  logic                mem_rd_en_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                wb_valid_q;
  logic [REG_W-1:0]    wb_dest_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                addr_err_q;
  logic                busy_q;
  logic                req_ready_q;

  logic                misaligned_c;
  logic [7:0]          byte_c;
  logic [15:0]         half_c;
  logic [DATA_W-1:0]   lwl_c;
  logic [DATA_W-1:0]   lwr_c;
  logic [DATA_W-1:0]   result_c;

  // Halfword needs an even address; word (and the lw alias) needs word alignment.
  always_comb begin
    misaligned_c = 1'b0;
    case (req_load_sel)
      SEL_LH, SEL_LHU:  misaligned_c = req_addr[0];
      SEL_LB, SEL_LBU,
      SEL_LWL, SEL_LWR: misaligned_c = 1'b0;
      default:          misaligned_c = (req_addr[1:0] != 2'b00);
    endcase
  end

  // Lane extraction and lwl/lwr merge from the returning word and captured fields.
  always_comb begin
    byte_c = mem_rdata[31:24];
    case (ofs_q)
      2'd0: byte_c = mem_rdata[31:24];
      2'd1: byte_c = mem_rdata[23:16];
      2'd2: byte_c = mem_rdata[15:8];
      default: byte_c = mem_rdata[7:0];
    endcase

    half_c = ofs_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    lwl_c = mem_rdata;
    case (ofs_q)
      2'd0: lwl_c = mem_rdata;
      2'd1: lwl_c = {mem_rdata[23:0], rt_q[7:0]};
      2'd2: lwl_c = {mem_rdata[15:0], rt_q[15:0]};
      default: lwl_c = {mem_rdata[7:0], rt_q[23:0]};
    endcase

    lwr_c = mem_rdata;
    case (ofs_q)
      2'd3: lwr_c = mem_rdata;
      2'd2: lwr_c = {rt_q[31:24], mem_rdata[31:8]};
      2'd1: lwr_c = {rt_q[31:16], mem_rdata[31:16]};
      default: lwr_c = {rt_q[31:8], mem_rdata[31:24]};
    endcase

    result_c = mem_rdata;
    case (sel_q)
      SEL_LB:  result_c = {{24{byte_c[7]}}, byte_c};
      SEL_LBU: result_c = {24'd0, byte_c};
      SEL_LH:  result_c = {{16{half_c[15]}}, half_c};
      SEL_LHU: result_c = {16'd0, half_c};
      SEL_LWL: result_c = lwl_c;
      SEL_LWR: result_c = lwr_c;
      default: result_c = mem_rdata;
    endcase
  end

  // Control FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ofs_q       <= 2'd0;
      sel_q       <= '0;
      rt_q        <= '0;
      dest_q      <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
      addr_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      mem_rd_en_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && !flush) begin
            ofs_q  <= req_addr[1:0];
            sel_q  <= req_load_sel;
            rt_q   <= req_rt_old;
            dest_q <= req_dest;
            if (misaligned_c) begin
              addr_err_q <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
              busy_q      <= 1'b1;
              req_ready_q <= 1'b0;
            end
          end
        end
        S_REQ, S_WAIT: begin
          if (flush) begin
            if (mem_rvalid) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              req_ready_q <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (mem_rvalid) begin
            state_q    <= S_DONE;
            wb_valid_q <= 1'b1;
            wb_dest_q  <= dest_q;
            wb_data_q  <= result_c;
            busy_q     <= 1'b0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        S_DRAIN: begin
          if (mem_rvalid) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // A redirect arriving during the writeback beat cancels it in the same cycle.
  assign wb_valid  = wb_valid_q & ~flush;
  assign req_ready = req_ready_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign wb_dest   = wb_dest_q;
  assign wb_data   = wb_data_q;
  assign addr_err  = addr_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: directed cases plus random loads
// compared against an arithmetic reference of the load rules.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_load_sel;
  logic [31:0] req_rt_old;
  logic [4:0]  req_dest;
  logic        flush;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        addr_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  load_align_unit #(.ADDR_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_load_sel(req_load_sel), .req_rt_old(req_rt_old), .req_dest(req_dest),
    .flush(flush),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .addr_err(addr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte lane k of a word lives at bit offset 8*(3-k).
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] sel,
                                           input logic [31:0] rt, input logic [31:0] m);
    int a;
    logic [7:0]  b;
    logic [15:0] h;
    a = int'(addr[1:0]);
    b = 8'(m >> (8 * (3 - a)));
    h = 16'(m >> (addr[1] ? 0 : 16));
    case (sel)
      3'd0: return {{24{b[7]}}, b};
      3'd1: return {24'd0, b};
      3'd2: return {{16{h[15]}}, h};
      3'd3: return {16'd0, h};
      3'd5: begin
        if (a == 0) return m;
        return (m << (8 * a)) | (rt & ((32'h1 << (8 * a)) - 32'h1));
      end
      3'd6: begin
        if (a == 3) return m;
        return (m >> (8 * (3 - a))) | (rt & ~(32'hFFFF_FFFF >> (8 * (3 - a))));
      end
      default: return m;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] sel, input logic [31:0] addr);
    if (sel == 3'd2 || sel == 3'd3) return addr[0];
    if (sel == 3'd4 || sel == 3'd7) return addr[1:0] != 2'b00;
    return 1'b0;
  endfunction

  task automatic drive_req(input logic [31:0] addr, input logic [2:0] sel,
                           input logic [31:0] rt, input logic [4:0] dest);
    @(negedge clk);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_load_sel = sel;
    req_rt_old   = rt;
    req_dest     = dest;
    @(negedge clk);
    req_valid    = 1'b0;
  endtask

  // Full load transaction; lat = cycles from the read strobe to mem_rvalid.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] sel,
                         input logic [31:0] rt, input logic [4:0] dest,
                         input logic [31:0] mdata, input int lat, input logic [31:0] exp);
    drive_req(addr, sel, rt, dest);
    if (ref_misaligned(sel, addr)) begin
      chk({tag, ".addr_err"}, 32'(addr_err), 32'd1);
      chk({tag, ".no_rd_en"}, 32'(mem_rd_en), 32'd0);
      chk({tag, ".ready"}, 32'(req_ready), 32'd1);
      @(negedge clk);
      chk({tag, ".err_pulse"}, 32'(addr_err), 32'd0);
      chk({tag, ".no_wb"}, 32'(wb_valid), 32'd0);
      chk({tag, ".no_rd_en2"}, 32'(mem_rd_en), 32'd0);
      return;
    end
    chk({tag, ".rd_en"}, 32'(mem_rd_en), 32'd1);
    chk({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".not_ready"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk({tag, ".wait_no_wb"}, 32'(wb_valid), 32'd0);
      chk({tag, ".wait_rd_en"}, 32'(mem_rd_en), 32'd0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = mdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, ".wb_data"}, wb_data, exp);
    chk({tag, ".wb_dest"}, 32'(wb_dest), 32'(dest));
    chk({tag, ".done_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, ".wb_pulse"}, 32'(wb_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a, rt, m;
    logic [2:0]  sel;
    logic [4:0]  dest;
    int          lat;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_load_sel = '0;
    req_rt_old = '0; req_dest = '0; flush = 1'b0;
    mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.wb_dest", 32'(wb_dest), 32'd0);
    chk("rst.addr_err", 32'(addr_err), 32'd0);

    // Byte and halfword extraction.
    do_load("lb100",  32'h100, 3'd0, 32'h0, 5'd3,  32'h80A1B2C3, 3, 32'hFFFFFF80);
    do_load("lbu103", 32'h103, 3'd1, 32'h0, 5'd7,  32'h80A1B2C3, 3, 32'h000000C3);
    do_load("lh202",  32'h202, 3'd2, 32'h0, 5'd9,  32'h8001F00F, 2, 32'hFFFFF00F);
    do_load("lhu200", 32'h200, 3'd3, 32'h0, 5'd10, 32'h8001F00F, 1, 32'h00008001);

    // lwl/lwr merge.
    do_load("lwl1", 32'h401, 3'd5, 32'h11223344, 5'd11, 32'hAABBCCDD, 1, 32'hBBCCDD44);
    do_load("lwr1", 32'h401, 3'd6, 32'h11223344, 5'd12, 32'hAABBCCDD, 2, 32'h1122AABB);
    do_load("lwl0", 32'h400, 3'd5, 32'h11223344, 5'd13, 32'hAABBCCDD, 0, 32'hAABBCCDD);
    do_load("lwr3", 32'h403, 3'd6, 32'h11223344, 5'd14, 32'hAABBCCDD, 0, 32'hAABBCCDD);
    do_load("sel7", 32'h404, 3'd7, 32'h0, 5'd15, 32'h12345678, 1, 32'h12345678);

    // Misaligned requests.
    do_load("mis_lw",  32'h102, 3'd4, 32'h0, 5'd1, 32'h0, 0, 32'h0);
    do_load("mis_lh",  32'h101, 3'd2, 32'h0, 5'd2, 32'h0, 0, 32'h0);
    do_load("mis_s7",  32'h103, 3'd7, 32'h0, 5'd2, 32'h0, 0, 32'h0);

    // Flush in WAIT: read drained 4 cycles later, no writeback.
    drive_req(32'h300, 3'd4, 32'h0, 5'd5);
    chk("fw.rd_en", 32'(mem_rd_en), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fw.drain_busy", 32'(busy), 32'd1);
    chk("fw.drain_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fw.busy_hold", 32'(busy), 32'd1);
      chk("fw.no_wb", 32'(wb_valid), 32'd0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("fw.idle_busy", 32'(busy), 32'd0);
    chk("fw.idle_ready", 32'(req_ready), 32'd1);
    chk("fw.idle_no_wb", 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk("fw.still_no_wb", 32'(wb_valid), 32'd0);
    do_load("after_fw", 32'h304, 3'd4, 32'h0, 5'd6, 32'hCAFEF00D, 2, 32'hCAFEF00D);

    // Flush in REQ with a concurrent response returns straight to IDLE.
    drive_req(32'h500, 3'd4, 32'h0, 5'd8);
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    flush = 1'b0; mem_rvalid = 1'b0;
    chk("fr.busy", 32'(busy), 32'd0);
    chk("fr.ready", 32'(req_ready), 32'd1);
    chk("fr.no_wb", 32'(wb_valid), 32'd0);

    // Flush in DONE cancels the writeback beat.
    drive_req(32'h600, 3'd4, 32'h0, 5'd16);
    mem_rvalid = 1'b1; mem_rdata = 32'h01020304;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("fd.wb_before", 32'(wb_valid), 32'd1);
    flush = 1'b1;
    #1;
    chk("fd.wb_killed", 32'(wb_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("fd.ready", 32'(req_ready), 32'd1);
    chk("fd.no_wb", 32'(wb_valid), 32'd0);

    // Flush in IDLE drops the request and hides the misalignment.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h102; req_load_sel = 3'd4;
    @(negedge clk);
    chk("fi.no_err", 32'(addr_err), 32'd0);
    req_addr = 32'h700;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("fi.no_rd_en", 32'(mem_rd_en), 32'd0);
    chk("fi.ready", 32'(req_ready), 32'd1);
    chk("fi.busy", 32'(busy), 32'd0);

    // Reset in WAIT clears everything.
    do_load("pre_rst", 32'h800, 3'd0, 32'h0, 5'd31, 32'h7F000000, 0, 32'h0000007F);
    drive_req(32'h804, 3'd4, 32'h0, 5'd30);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rw.ready", 32'(req_ready), 32'd1);
    chk("rw.busy", 32'(busy), 32'd0);
    chk("rw.rd_en", 32'(mem_rd_en), 32'd0);
    chk("rw.mem_addr", mem_addr, 32'd0);
    chk("rw.wb_data", wb_data, 32'd0);
    chk("rw.wb_dest", 32'(wb_dest), 32'd0);
    chk("rw.wb_valid", 32'(wb_valid), 32'd0);
    chk("rw.addr_err", 32'(addr_err), 32'd0);

    // Random loads against the reference.
    for (int n = 0; n < 60; n++) begin
      a    = $urandom;
      sel  = 3'($urandom_range(0, 7));
      rt   = $urandom;
      m    = $urandom;
      dest = 5'($urandom_range(0, 31));
      lat  = int'($urandom_range(0, 3));
      do_load("rand", a, sel, rt, dest, m, lat, ref_load(a, sel, rt, m));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
